// File: rtl/fixed_to_fp_pkg.sv
// rtl/fixed_to_fp_pkg.sv - shared widths, sample type and constants for the fixed-to-float path
package fixed_to_fp_pkg;

  localparam int FRAC_W = 19;
  localparam int FP_W   = 32;

  localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;

  // One fixed-point sample: sign-magnitude, magnitude = int_bit + frac / 2^FRAC_W
  typedef struct packed {
    logic              sign;
    logic              int_bit;
    logic [FRAC_W-1:0] frac;
  } fixed_sample_t;

  // True when the magnitude is exactly zero (no leading one for the converter)
  function automatic logic fixed_is_zero(input fixed_sample_t s);
    return !s.int_bit && (s.frac == '0);
  endfunction

endpackage

// File: rtl/fixed_to_fp.sv
// rtl/fixed_to_fp.sv - combinational sign/int/19-bit-fraction to IEEE-754 single converter
module fixed_to_fp
  import fixed_to_fp_pkg::*;
(
  input  logic              i_sign,
  input  logic              i_int,
  input  logic [FRAC_W-1:0] i_frac,
  output logic [FP_W-1:0]   o_fp
);

  localparam int MANT_W   = 23;
  localparam int EXP_BIAS = 127;
  localparam int LEAD_W   = $clog2(FRAC_W + 1);

  logic [FRAC_W:0]   w_mag;
  logic [LEAD_W-1:0] w_lead;
  logic [MANT_W-1:0] w_mant;
  logic [7:0]        w_exp;

  assign w_mag = {i_int, i_frac};

  // Position of the most significant set bit of the magnitude
  always_comb begin
    w_lead = '0;
    for (int i = 0; i <= FRAC_W; i++) begin
      if (w_mag[i]) w_lead = LEAD_W'(i);
    end
  end

  // The leading one is shifted out past bit MANT_W-1; at most 19 bits remain, so no rounding
  assign w_mant = MANT_W'(w_mag) << (LEAD_W'(MANT_W) - w_lead);

  // Bit position p of the leading one has weight 2^(p - FRAC_W)
  assign w_exp = 8'(EXP_BIAS - FRAC_W) + 8'(w_lead);

  assign o_fp = (w_mag == '0) ? {i_sign, FP_POS_ZERO[FP_W-2:0]} : {i_sign, w_exp, w_mant};

endmodule

// File: rtl/fixed_to_fp_arbiter.sv
// rtl/fixed_to_fp_arbiter.sv - N-way arbiter sharing one fixed_to_fp converter; FIXED_TO_FP_ARB_RR_EN selects round-robin
module fixed_to_fp_arbiter
  import fixed_to_fp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ-1:0]        req_sign_i,
  input  logic [N_REQ-1:0]        req_integer_i,
  input  logic [N_REQ*FRAC_W-1:0] req_frac_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [FP_W-1:0]         out_fp_o,
  output logic [ID_W-1:0]         out_id_o,
  output logic [15:0]             conv_count_o
);

  logic             r_out_valid;
  logic [FP_W-1:0]  r_out_fp;
  logic [ID_W-1:0]  r_out_id;
  logic [15:0]      r_conv_count;

  logic             w_load;
  logic             w_grant_vld;
  logic [ID_W-1:0]  w_grant_idx;
  logic [N_REQ-1:0] w_grant_oh;
  logic             w_xfer;
  fixed_sample_t    w_sel;
  logic [FP_W-1:0]  w_conv_fp;
  logic [FP_W-1:0]  w_result;

`ifdef FIXED_TO_FP_ARB_RR_EN
  logic [ID_W-1:0]    r_ptr;
  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;

  assign w_dbl = {req_valid_i, req_valid_i};
  assign w_rot = N_REQ'(w_dbl >> r_ptr);

  // Round-robin: first valid requester at or after the pointer, wrapping modulo N_REQ
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (w_rot[off]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = ID_W'((int'(r_ptr) + off) % N_REQ);
      end
    end
  end
`else
  // Fixed priority: lowest valid index wins
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[k]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = ID_W'(k);
      end
    end
  end
`endif

  assign w_load      = !r_out_valid || out_ready_i;
  assign w_grant_oh  = w_grant_vld ? (N_REQ'(1) << w_grant_idx) : '0;
  // Gated by rst_ni so no requester sees an accept while reset is held
  assign req_ready_o = (w_load && rst_ni) ? w_grant_oh : '0;
  assign w_xfer      = w_grant_vld && w_load;

  // Steer the granted requester's fields into the shared converter
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_grant_oh[k]) begin
        w_sel.sign    = req_sign_i[k];
        w_sel.int_bit = req_integer_i[k];
        w_sel.frac    = req_frac_i[FRAC_W*k +: FRAC_W];
      end
    end
  end

  fixed_to_fp u_conv (
    .i_sign (w_sel.sign),
    .i_int  (w_sel.int_bit),
    .i_frac (w_sel.frac),
    .o_fp   (w_conv_fp)
  );

  assign w_result = fixed_is_zero(w_sel) ? {w_sel.sign, FP_POS_ZERO[FP_W-2:0]} : w_conv_fp;

  // Output register: load on transfer, clear on a pop with nothing behind it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_valid <= 1'b0;
      r_out_fp    <= FP_POS_ZERO;
      r_out_id    <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_fp    <= w_result;
      r_out_id    <= w_grant_idx;
    end else if (out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  // Accepted-conversion counter, wraps at 16 bits
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_conv_count <= '0;
    end else if (w_xfer) begin
      r_conv_count <= r_conv_count + 16'd1;
    end
  end

`ifdef FIXED_TO_FP_ARB_RR_EN
  // Pointer moves to the slot after the winner; held when nothing transfers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= ID_W'((int'(w_grant_idx) + 1) % N_REQ);
    end
  end
`endif

  assign out_valid_o  = r_out_valid;
  assign out_fp_o     = r_out_fp;
  assign out_id_o     = r_out_id;
  assign conv_count_o = r_conv_count;

endmodule

// File: tb/tb_fixed_to_fp_arbiter.sv
// tb/tb_fixed_to_fp_arbiter.sv - scoreboard bench for fixed_to_fp_arbiter with directed vectors
module tb_fixed_to_fp_arbiter;

  localparam int N = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [N-1:0]  req_valid_i;
  logic [N-1:0]  req_ready_o;
  logic [N-1:0]  req_sign_i;
  logic [N-1:0]  req_integer_i;
  logic [N*19-1:0] req_frac_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [31:0]   out_fp_o;
  logic [1:0]    out_id_o;
  logic [15:0]   conv_count_o;

  always #5 clk_i = ~clk_i;

  fixed_to_fp_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_sign_i    (req_sign_i),
    .req_integer_i (req_integer_i),
    .req_frac_i    (req_frac_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_fp_o      (out_fp_o),
    .out_id_o      (out_id_o),
    .conv_count_o  (conv_count_o)
  );

  typedef struct {
    logic [31:0] fp;
    logic [1:0]  id;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    int          k;
    logic        s;
    logic        ib;
    logic [18:0] f;
    logic [31:0] fp;
  } vec_t;

  exp_t        exp_q[$];
  logic [15:0] exp_cnt = 16'd0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] fp, input logic [1:0] id);
    exp_t e;
    exp_cnt = exp_cnt + 16'd1;
    e.fp  = fp;
    e.id  = id;
    e.cnt = exp_cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: every pop (valid && ready) is matched against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && out_valid_o && out_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pop_unexpected: got fp=%h id=%0d with empty scoreboard", out_fp_o, out_id_o);
        end else begin
          e = exp_q.pop_front();
          if (out_fp_o !== e.fp || out_id_o !== e.id || conv_count_o !== e.cnt) begin
            failures++;
            $display("FAIL pop: got fp=%h id=%0d cnt=%h required fp=%h id=%0d cnt=%h",
                     out_fp_o, out_id_o, conv_count_o, e.fp, e.id, e.cnt);
          end
        end
      end
    end
  end

  // Present one sample on requester k and wait (bounded) for its accept
  task automatic send(input int k, input logic s, input logic ib, input logic [18:0] f,
                      input logic [31:0] efp);
    bit got = 0;
    req_valid_i[k]   = 1'b1;
    req_sign_i[k]    = s;
    req_integer_i[k] = ib;
    req_frac_i[19*k +: 19] = f;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk_i);
      if (req_ready_o[k]) begin
        got = 1;
        push(efp, 2'(k));
      end
      @(posedge clk_i);
      #1;
    end
    req_valid_i[k] = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL send_timeout: requester %0d never accepted, required accept within 20 cycles", k);
    end
  endtask

  vec_t vecs[10];
  logic [31:0] rr_fp[4];

  initial begin
    vecs[0] = '{1, 1'b0, 1'b0, 19'h40000, 32'h3F00_0000};
    vecs[1] = '{0, 1'b1, 1'b0, 19'h40000, 32'hBF00_0000};
    vecs[2] = '{2, 1'b0, 1'b0, 19'h20000, 32'h3E80_0000};
    vecs[3] = '{3, 1'b0, 1'b0, 19'h00000, 32'h0000_0000};
    vecs[4] = '{1, 1'b1, 1'b0, 19'h00000, 32'h8000_0000};
    vecs[5] = '{0, 1'b0, 1'b1, 19'h00000, 32'h3F80_0000};
    vecs[6] = '{2, 1'b1, 1'b1, 19'h00000, 32'hBF80_0000};
    vecs[7] = '{3, 1'b0, 1'b0, 19'h60000, 32'h3F40_0000};
    vecs[8] = '{0, 1'b0, 1'b0, 19'h00001, 32'h3600_0000};
    vecs[9] = '{1, 1'b0, 1'b0, 19'h7FFFF, 32'h3F7F_FFE0};

    rr_fp[0] = 32'h3F00_0000;
    rr_fp[1] = 32'h3E80_0000;
    rr_fp[2] = 32'h3E00_0000;
    rr_fp[3] = 32'h3F80_0000;

    // Reset state, with every requester asserting valid during reset
    rst_ni        = 1'b0;
    req_valid_i   = '1;
    req_sign_i    = '0;
    req_integer_i = '0;
    req_frac_i    = '0;
    out_ready_i   = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_out_fp", out_fp_o, 32'd0);
    chk("rst_out_id", 32'(out_id_o), 32'd0);
    chk("rst_count", 32'(conv_count_o), 32'd0);
    chk("rst_req_ready", 32'(req_ready_o), 32'd0);
    req_valid_i = '0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Single request, then direct look at the registered result
    send(vecs[0].k, vecs[0].s, vecs[0].ib, vecs[0].f, vecs[0].fp);
    @(negedge clk_i);
    chk("single_fp", out_fp_o, 32'h3F00_0000);
    chk("single_id", 32'(out_id_o), 32'd1);
    chk("single_count", 32'(conv_count_o), 32'd1);
    @(posedge clk_i); #1;

    // Sign, scaling and zero-bypass vectors, back to back
    for (int i = 1; i < 10; i++) send(vecs[i].k, vecs[i].s, vecs[i].ib, vecs[i].f, vecs[i].fp);
    repeat (2) @(posedge clk_i);
    #1;

    // Backpressure: one result pending, next requester waits three stalled cycles
    out_ready_i    = 1'b0;
    req_valid_i[2] = 1'b1;
    req_sign_i[2]  = 1'b0;
    req_integer_i[2] = 1'b0;
    req_frac_i[38 +: 19] = 19'h60000;
    @(negedge clk_i);
    chk("bp_first_ready", 32'(req_ready_o), 32'h4);
    push(32'h3F40_0000, 2'd2);
    @(posedge clk_i); #1;
    req_valid_i[2] = 1'b0;
    req_valid_i[3] = 1'b1;
    req_sign_i[3]  = 1'b0;
    req_integer_i[3] = 1'b0;
    req_frac_i[57 +: 19] = 19'h10000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("bp_stall_ready", 32'(req_ready_o), 32'd0);
      chk("bp_stall_valid", 32'(out_valid_o), 32'd1);
      chk("bp_stall_fp", out_fp_o, 32'h3F40_0000);
      chk("bp_stall_id", 32'(out_id_o), 32'd2);
      @(posedge clk_i); #1;
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_release_ready", 32'(req_ready_o), 32'h8);
    push(32'h3E00_0000, 2'd3);
    @(posedge clk_i); #1;
    req_valid_i[3] = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    // Reset mid-stream: outputs and accepts drop without a clock edge
    req_valid_i[0] = 1'b1;
    req_sign_i[0]  = 1'b0;
    req_integer_i[0] = 1'b0;
    req_frac_i[0 +: 19] = 19'h40000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      push(32'h3F00_0000, 2'd0);
      @(posedge clk_i);
    end
    #3;
    rst_ni = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid_o), 32'd0);
    chk("midrst_req_ready", 32'(req_ready_o), 32'd0);
    chk("midrst_count", 32'(conv_count_o), 32'd0);
    chk("midrst_out_fp", out_fp_o, 32'd0);
    exp_q.delete();
    exp_cnt = 16'd0;
    req_valid_i = '0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Arbitration: all four requesters valid continuously, pointer starts at 0
    for (int k = 0; k < 4; k++) begin
      req_sign_i[k]    = 1'b0;
      req_integer_i[k] = (k == 3);
    end
    req_frac_i[0 +: 19]  = 19'h40000;
    req_frac_i[19 +: 19] = 19'h20000;
    req_frac_i[38 +: 19] = 19'h10000;
    req_frac_i[57 +: 19] = 19'h00000;
    req_valid_i = '1;
    for (int i = 0; i < 5; i++) begin
      int id;
`ifdef FIXED_TO_FP_ARB_RR_EN
      id = i % 4;
`else
      id = 0;
`endif
      @(negedge clk_i);
      chk("arb_ready", 32'(req_ready_o), 32'(1) << id);
      push(rr_fp[id], 2'(id));
      @(posedge clk_i); #1;
    end
    req_valid_i = '0;
    repeat (2) @(posedge clk_i);
    #1;

    // Counter wrap: stream requester 0 up to 0xFFFF, then one more transfer
    req_valid_i[0] = 1'b1;
    for (int n = 0; n < 70000 && exp_cnt != 16'hFFFF; n++) begin
      @(negedge clk_i);
      push(32'h3F00_0000, 2'd0);
      @(posedge clk_i);
    end
    @(negedge clk_i);
    chk("wrap_count_ffff", 32'(conv_count_o), 32'h0000_FFFF);
    push(32'h3F00_0000, 2'd0);
    @(posedge clk_i); #1;
    req_valid_i[0] = 1'b0;
    @(negedge clk_i);
    chk("wrap_count_zero", 32'(conv_count_o), 32'd0);
    repeat (3) @(posedge clk_i);
    #1;

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
